dff_chain_readback: RTL and testbench

Self-test engine for chains of standard-cell flip-flops: launches an 8-bit LFSR pattern into the serial input of an external chain of `CHAIN_LEN` D flip-flops clocked by the same `CLK`. It reads the chain's serial output back `CHAIN_LEN` cycles later, compares it against a delayed copy of the same LFSR, and reports error count, first-failing bit index and pass/fail. It sits beside characterization and regression benches as the readback end of the flop chain under test.

---
 rtl/dff_chain_readback.sv | 144 ++++++++++++++
 tb/tb_dff_chain_readback.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_chain_readback.sv
// rtl/dff_chain_readback.sv - LFSR launch/readback self-test for an external D flip-flop chain
module dff_chain_readback #(
  parameter int         CHAIN_LEN = 16,
  parameter int         PAT_LEN   = 64,
  parameter logic [7:0] SEED      = 8'hA5,
  parameter int         ERRW      = 8
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic            START,
  input  logic            SO,
  output logic            SI,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [ERRW-1:0] ERR_CNT,
  output logic [15:0]     FIRST_ERR
);

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [7:0]      SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  // 17 bits covers the longest run of CHAIN_LEN + PAT_LEN cycles.
  localparam logic [16:0]     N_C      = 17'(CHAIN_LEN);
  localparam logic [16:0]     P_C      = 17'(PAT_LEN);
  localparam logic [16:0]     LAST_C   = 17'(CHAIN_LEN + PAT_LEN - 1);
  localparam logic [ERRW-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_REPORT
  } state_t;

  state_t          state_q, state_d;
  logic [16:0]     cnt_q, cnt_d, cnt_inc;
  logic [7:0]      launch_q, launch_d;
  logic [7:0]      expect_q, expect_d;
  logic            si_d, busy_d, done_d, pass_d;
  logic [ERRW-1:0] err_d;
  logic [15:0]     first_d;

  // Fibonacci step: shift left, feedback from taps 7,5,4,3; the emitted bit is q[7].
  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // Next-state and next-output logic; every output is a register so inputs never reach outputs combinationally.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    launch_d = launch_q;
    expect_d = expect_q;
    si_d     = 1'b0;
    busy_d   = BUSY;
    done_d   = 1'b0;
    pass_d   = PASS;
    err_d    = ERR_CNT;
    first_d  = FIRST_ERR;
    cnt_inc  = cnt_q + 17'd1;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          err_d    = '0;
          first_d  = 16'hFFFF;
          pass_d   = 1'b0;
          launch_d = SEED_EFF;
          expect_d = SEED_EFF;
          cnt_d    = '0;
          // b_0 must already be on SI in the first RUN cycle.
          si_d     = SEED_EFF[7];
        end
      end

      S_RUN: begin
        launch_d = lfsr_step(launch_q);
        // SI for the following cycle carries the next pattern bit while still inside the launch window.
        if (cnt_inc < P_C) begin
          si_d = launch_d[7];
        end
        // Bit b_k reaches SO exactly CHAIN_LEN cycles after launch, so checking starts at c = CHAIN_LEN.
        if (cnt_q >= N_C) begin
          expect_d = lfsr_step(expect_q);
          if (SO != expect_q[7]) begin
            if (ERR_CNT != ERR_MAX) begin
              err_d = ERR_CNT + ERRW'(1);
            end
            if (FIRST_ERR == 16'hFFFF) begin
              first_d = 16'(cnt_q - N_C);
            end
          end
        end
        if (cnt_q == LAST_C) begin
          state_d = S_REPORT;
          done_d  = 1'b1;
          // Uses the updated count so a mismatch in the final cycle is reflected.
          pass_d  = (err_d == '0);
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_REPORT: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous return to the reset values.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      launch_q  <= SEED_EFF;
      expect_q  <= SEED_EFF;
      SI        <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      ERR_CNT   <= '0;
      FIRST_ERR <= 16'hFFFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      launch_q  <= launch_d;
      expect_q  <= expect_d;
      SI        <= si_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      PASS      <= pass_d;
      ERR_CNT   <= err_d;
      FIRST_ERR <= first_d;
    end
  end

endmodule

// File: tb/tb_dff_chain_readback.sv
// tb/tb_dff_chain_readback.sv - scoreboard bench for dff_chain_readback with modelled flop chains and SO faults
module tb_dff_chain_readback;

  localparam int N = 16;
  localparam int P = 64;
  localparam int T = N + P;

  logic CLK = 1'b0;
  logic RN = 1'b0;
  logic START = 1'b0;
  always #5 CLK = ~CLK;

  logic        so_a, so_b, si_a, si_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0]  err_a;
  logic [3:0]  err_b;
  logic [15:0] first_a, first_b;

  dff_chain_readback #(.CHAIN_LEN(N), .PAT_LEN(P), .SEED(8'hA5), .ERRW(8)) dut_a (
    .CLK(CLK), .RN(RN), .START(START), .SO(so_a), .SI(si_a),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR_CNT(err_a), .FIRST_ERR(first_a)
  );

  dff_chain_readback #(.CHAIN_LEN(N), .PAT_LEN(P), .SEED(8'hA5), .ERRW(4)) dut_b (
    .CLK(CLK), .RN(RN), .START(START), .SO(so_b), .SI(si_b),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR_CNT(err_b), .FIRST_ERR(first_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int gcyc = 0;

  // External flop chains; scramble loads arbitrary stale contents.
  logic [N-1:0] chain_a, chain_b, junk;
  logic         scramble = 1'b0;
  always @(posedge CLK) begin
    if (scramble) begin
      chain_a <= junk;
      chain_b <= ~junk;
    end else begin
      chain_a <= {chain_a[N-2:0], si_a};
      chain_b <= {chain_b[N-2:0], si_b};
    end
  end

  always @(posedge CLK) gcyc <= gcyc + 1;

  // Per-run-cycle SO fault: 0 pass, 1 stuck-0, 2 stuck-1, 3 invert.
  logic [1:0] mode [T];
  int         cyc = -1;
  logic       ref_bits [P];

  function automatic logic apply_mode(input logic [1:0] m, input logic v);
    case (m)
      2'd0:    return v;
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return ~v;
    endcase
  endfunction

  always_comb begin
    so_a = apply_mode((cyc >= 0 && cyc < T) ? mode[cyc] : 2'd0, chain_a[N-1]);
    so_b = apply_mode((cyc >= 0 && cyc < T) ? mode[cyc] : 2'd0, chain_b[N-1]);
  end

  typedef struct {
    int e_idx;
    int err;
    int first;
  } exp_t;
  exp_t sb[$];

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every DONE and measures pulse/busy timing.
  int busy_run = 0;
  bit prev_done = 1'b0;
  int done_total = 0;
  always @(negedge CLK) begin
    exp_t e;
    if (!RN) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy_a) busy_run++;
      if (prev_done) check("done_pulse_width", done_a, 0);
      if (done_a) begin
        done_total++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got DONE at cycle %0d, expected none", gcyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle_after_accept", gcyc - e.e_idx, N + P + 1);
          check("busy_length", busy_run, N + P + 1);
          check("done_b_aligned", done_b, 1);
          check("err_cnt_a", err_a, sat(e.err, 255));
          check("first_err_a", first_a, e.first);
          check("pass_a", pass_a, (e.err == 0) ? 1 : 0);
          check("err_cnt_b_sat4", err_b, sat(e.err, 15));
          check("first_err_b", first_b, e.first);
          check("pass_b", pass_b, (e.err == 0) ? 1 : 0);
        end
      end
      if (!busy_a) busy_run = 0;
      prev_done = done_a;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_si"}, si_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_pass"}, pass_a, 0);
    check({tag, "_err_a"}, err_a, 0);
    check({tag, "_err_b"}, err_b, 0);
    check({tag, "_first"}, first_a, 16'hFFFF);
  endtask

  // kind: 0 good, 1 stuck-0, 2 flip at k=arg, 3 invert all, 4 random faults at arg percent.
  task automatic set_modes(input int kind, input int arg);
    for (int c = 0; c < T; c++) begin
      if (c < N) mode[c] = 2'($urandom_range(0, 3));
      else begin
        case (kind)
          0: mode[c] = 2'd0;
          1: mode[c] = 2'd1;
          2: mode[c] = (c == N + arg) ? 2'd3 : 2'd0;
          3: mode[c] = 2'd3;
          default: mode[c] = ($urandom_range(0, 99) < arg) ? 2'($urandom_range(1, 3)) : 2'd0;
        endcase
      end
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle following REPORT.
  task automatic do_run(input int abort_at, input bit hold);
    exp_t e;
    int   err;
    int   first;
    int   si_bad;
    logic obs;
    err = 0;
    first = 16'hFFFF;
    si_bad = 0;
    for (int k = 0; k < P; k++) begin
      obs = apply_mode(mode[N + k], ref_bits[k]);
      if (obs != ref_bits[k]) begin
        err++;
        if (first == 16'hFFFF) first = k;
      end
    end
    e.e_idx = gcyc;
    e.err = err;
    e.first = first;
    check("idle_before_accept", busy_a, 0);
    if (abort_at < 0) sb.push_back(e);
    START = 1'b1;
    @(negedge CLK);
    if (!hold) START = 1'b0;
    check("accept_busy", busy_a, 1);
    check("accept_err_cleared", err_a, 0);
    check("accept_first_cleared", first_a, 16'hFFFF);
    check("accept_pass_cleared", pass_a, 0);
    for (int i = 0; i < T; i++) begin
      cyc = i;
      if (si_a !== ((i < P) ? ref_bits[i] : 1'b0)) si_bad++;
      if (i == abort_at) begin
        RN = 1'b0;
        #1;
        check_reset("abort");
        @(negedge CLK);
        RN = 1'b1;
        cyc = -1;
        return;
      end
      @(negedge CLK);
    end
    check("si_sequence_errors", si_bad, 0);
    cyc = -1;
    @(negedge CLK);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: time %0t, limit 300000", $time);
    $fatal(1);
  end

  initial begin
    int st;
    int fb;
    int dn;
    int kind;
    st = 'hA5;
    for (int i = 0; i < P; i++) begin
      ref_bits[i] = 1'((st / 128) % 2);
      fb = ((st / 128) + (st / 32) + (st / 16) + (st / 8)) % 2;
      st = (st * 2 + fb) % 256;
    end
    for (int c = 0; c < T; c++) mode[c] = 2'd0;

    junk = N'($urandom);
    scramble = 1'b1;
    RN = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset("por");
    scramble = 1'b0;
    RN = 1'b1;
    repeat (2) @(negedge CLK);

    set_modes(0, 0);  do_run(-1, 0);
    set_modes(1, 0);  do_run(-1, 0);
    set_modes(2, 10); do_run(-1, 0);
    set_modes(3, 0);  do_run(-1, 0);

    set_modes(0, 0);
    do_run(20, 0);
    dn = done_total;
    repeat (T + 5) @(negedge CLK);
    check("done_after_abort", done_total - dn, 0);
    check_reset("post_abort");
    set_modes(0, 0);  do_run(-1, 0);

    set_modes(3, 0);  do_run(-1, 1);
    set_modes(0, 0);  do_run(-1, 1);
    START = 1'b0;
    @(negedge CLK);

    for (int r = 0; r < 6; r++) begin
      kind = $urandom_range(0, 4);
      set_modes(kind, (kind == 2) ? $urandom_range(0, P - 1) : $urandom_range(1, 30));
      do_run(-1, 0);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    for (int w = 0; w < 200 && sb.size() > 0; w++) @(negedge CLK);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
